call_ret_ctrl: RTL and testbench

Program-counter sequencer that sits directly upstream of the 32-entry return-address stack and drives its push/pop/data inputs. It advances the PC, takes jumps and taken branches, pushes PC+1 on CALL, and on RET pops the stack and waits out its registered output before loading the PC. It also keeps a shadow depth count, because the stack silently drops overflowing pushes and underflowing pops.

---
 rtl/call_ret_ctrl_pkg.sv | 40 ++++
 rtl/call_ret_ctrl_if.sv | 35 +++
 rtl/call_ret_ctrl.sv | 93 +++++++++
 tb/tb_call_ret_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/call_ret_ctrl_pkg.sv
// Shared types and constants for the call/return PC sequencer
// and the return-address stack it drives.
package call_ret_ctrl_pkg;

    localparam int PC_WIDTH = 32;
    localparam int STACK_DEPTH = 32;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    typedef enum logic {
        RUN,
        RET_WAIT
    } state_t;

    typedef enum logic [2:0] {
        CF_RET,
        CF_CALL,
        CF_JUMP,
        CF_BR,
        CF_SEQ
    } cf_t;

    // Flags may overlap; the first match wins.
    function automatic cf_t cf_decode(
        input logic r,
        input logic c,
        input logic j,
        input logic b
    );
        cf_t cf;
        priority case (1'b1)
            r: cf = CF_RET;
            c: cf = CF_CALL;
            j: cf = CF_JUMP;
            b: cf = CF_BR;
            default: cf = CF_SEQ;
        endcase
        return cf;
    endfunction

endpackage

// File: rtl/call_ret_ctrl_if.sv
// Decode-side and stack-side signals of the PC sequencer.
interface call_ret_ctrl_if #(
    parameter int PC_W = 32,
    parameter int DEPTH = 32
);
    logic                     instr_valid;
    logic                     is_call;
    logic                     is_ret;
    logic                     is_jump;
    logic                     br_taken;
    logic [PC_W-1:0]          target;
    logic [PC_W-1:0]          stack_out;
    logic [PC_W-1:0]          pc;
    logic                     stall;
    logic                     stack_push;
    logic                     stack_pop;
    logic [PC_W-1:0]          stack_in;
    logic [$clog2(DEPTH):0]   depth;
    logic                     ovf_err;
    logic                     unf_err;

    modport master (
        output instr_valid, is_call, is_ret, is_jump, br_taken,
        output target, stack_out,
        input  pc, stall, stack_push, stack_pop, stack_in,
        input  depth, ovf_err, unf_err
    );

    modport slave (
        input  instr_valid, is_call, is_ret, is_jump, br_taken,
        input  target, stack_out,
        output pc, stall, stack_push, stack_pop, stack_in,
        output depth, ovf_err, unf_err
    );
endinterface

// File: rtl/call_ret_ctrl.sv
// PC sequencer feeding the return-address stack; tracks a shadow
// stack depth so dropped pushes/pops are flagged.
module call_ret_ctrl #(
    parameter int PC_W = call_ret_ctrl_pkg::PC_WIDTH,
    parameter int DEPTH = call_ret_ctrl_pkg::STACK_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(call_ret_ctrl_pkg::RESET_PC)
) (
    input logic              clk,
    input logic              rst_n,
    call_ret_ctrl_if.slave   bus
);
    import call_ret_ctrl_pkg::*;

    localparam int DW = $clog2(DEPTH) + 1;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n, pc_inc;
    logic [DW-1:0]   depth, depth_n;
    logic            ovf, ovf_n;
    logic            unf, unf_n;
    logic            push, pop;
    logic            full;
    cf_t             cf;

    assign pc_inc = pc + PC_W'(1);
    assign full   = (depth == DW'(DEPTH));
    assign cf     = cf_decode(bus.is_ret, bus.is_call,
                              bus.is_jump, bus.br_taken);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        depth_n = depth;
        ovf_n   = ovf;
        unf_n   = unf;
        push    = 1'b0;
        pop     = 1'b0;
        if (state == RET_WAIT) begin
            pc_n    = bus.stack_out;
            state_n = RUN;
        end else if (bus.instr_valid) begin
            unique case (cf)
                CF_RET: begin
                    if (depth != '0) begin
                        pop     = 1'b1;
                        depth_n = depth - DW'(1);
                        state_n = RET_WAIT;
                    end else begin
                        unf_n = 1'b1;
                        pc_n  = pc_inc;
                    end
                end
                CF_CALL: begin
                    pc_n = bus.target;
                    if (!full) begin
                        push    = 1'b1;
                        depth_n = depth + DW'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                CF_JUMP, CF_BR: pc_n = bus.target;
                default:        pc_n = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            depth <= depth_n;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end

    assign bus.pc         = pc;
    assign bus.stall      = (state == RET_WAIT);
    assign bus.stack_push = push;
    assign bus.stack_pop  = pop;
    assign bus.stack_in   = pc_inc;
    assign bus.depth      = depth;
    assign bus.ovf_err    = ovf;
    assign bus.unf_err    = unf;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Bench for call_ret_ctrl: vector table, corner sequences and a
// random run against a queue-based reference model.
module tb_call_ret_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    call_ret_ctrl_if #(.PC_W(32), .DEPTH(32)) bus ();

    call_ret_ctrl #(.PC_W(32), .DEPTH(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Return-address stack with registered pop output.
    logic [31:0] mem [32];
    int          sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= 0;
            bus.stack_out <= '0;
        end else begin
            if (bus.stack_push && sp < 32) begin
                mem[sp] <= bus.stack_in;
                sp <= sp + 1;
            end
            if (bus.stack_pop && sp > 0) begin
                bus.stack_out <= mem[sp-1];
                sp <= sp - 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic drive(input logic v, c, r, j, b,
                         input logic [31:0] t);
        bus.instr_valid = v;
        bus.is_call     = c;
        bus.is_ret      = r;
        bus.is_jump     = j;
        bus.br_taken    = b;
        bus.target      = t;
    endtask

    task automatic tick(input logic v, c, r, j, b,
                        input logic [31:0] t,
                        output logic o_push, o_pop, o_stall,
                        output logic [31:0] o_sin);
        drive(v, c, r, j, b, t);
        @(negedge clk);
        o_push  = bus.stack_push;
        o_pop   = bus.stack_pop;
        o_stall = bus.stall;
        o_sin   = bus.stack_in;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        logic        v, c, r, j, b;
        logic [31:0] t;
        logic        ep, eo, es;
        logic [31:0] esin, epc;
        int          ed;
    } vec_t;

    vec_t tbl [12];

    logic        p, o, s;
    logic [31:0] si;

    // Reference model state
    logic [31:0] m_pc, m_ret;
    logic [31:0] q [$];
    bit          m_wait, m_ovf, m_unf;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        tbl[0]  = '{1,0,0,0,0, 32'h0,  0,0,0, 32'h1,  32'h1,  0};
        tbl[1]  = '{1,0,0,0,0, 32'h0,  0,0,0, 32'h2,  32'h2,  0};
        tbl[2]  = '{1,0,0,0,0, 32'h0,  0,0,0, 32'h3,  32'h3,  0};
        tbl[3]  = '{1,0,0,0,0, 32'h0,  0,0,0, 32'h4,  32'h4,  0};
        tbl[4]  = '{1,0,0,0,0, 32'h0,  0,0,0, 32'h5,  32'h5,  0};
        tbl[5]  = '{1,1,0,0,0, 32'h40, 1,0,0, 32'h6,  32'h40, 1};
        tbl[6]  = '{1,0,1,0,0, 32'h0,  0,1,0, 32'h41, 32'h40, 0};
        tbl[7]  = '{1,0,0,1,0, 32'h99, 0,0,1, 32'h41, 32'h6,  0};
        tbl[8]  = '{1,0,0,1,0, 32'h8,  0,0,0, 32'h7,  32'h8,  0};
        tbl[9]  = '{1,0,0,0,1, 32'h9,  0,0,0, 32'h9,  32'h9,  0};
        tbl[10] = '{1,0,1,0,0, 32'h0,  0,0,0, 32'ha,  32'ha,  0};
        tbl[11] = '{0,0,0,1,0, 32'h77, 0,0,0, 32'hb,  32'ha,  0};

        do_reset();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_push", bus.stack_push, 0);
        chk("rst_pop", bus.stack_pop, 0);
        chk("rst_sin", bus.stack_in, 32'h1);
        chk("rst_depth", bus.depth, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_unf", bus.unf_err, 0);

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].v, tbl[i].c, tbl[i].r, tbl[i].j, tbl[i].b,
                 tbl[i].t, p, o, s, si);
            chk($sformatf("v%0d_push", i), p, tbl[i].ep);
            chk($sformatf("v%0d_pop", i), o, tbl[i].eo);
            chk($sformatf("v%0d_stall", i), s, tbl[i].es);
            chk($sformatf("v%0d_sin", i), si, tbl[i].esin);
            chk($sformatf("v%0d_pc", i), bus.pc, tbl[i].epc);
            chk($sformatf("v%0d_depth", i), bus.depth, 64'(tbl[i].ed));
        end
        chk("unf_set", bus.unf_err, 1);
        chk("unf_no_ovf", bus.ovf_err, 0);

        // PC wrap
        tick(1, 0, 0, 1, 0, 32'hFFFF_FFFF, p, o, s, si);
        tick(1, 0, 0, 0, 0, 32'h0, p, o, s, si);
        chk("wrap_sin", si, 32'h0);
        chk("wrap_pc", bus.pc, 32'h0);

        // Overflow
        do_reset();
        for (int i = 0; i < 33; i++) begin
            tick(1, 1, 0, 0, 0, 32'h100, p, o, s, si);
            chk($sformatf("ovf%0d_push", i), p, (i < 32));
            chk($sformatf("ovf%0d_depth", i), bus.depth,
                (i < 32) ? i + 1 : 32);
            chk($sformatf("ovf%0d_pc", i), bus.pc, 32'h100);
        end
        chk("ovf_set", bus.ovf_err, 1);
        chk("ovf_no_unf", bus.unf_err, 0);

        // RET beats CALL
        do_reset();
        tick(1, 1, 0, 0, 0, 32'h100, p, o, s, si);
        tick(1, 1, 0, 0, 0, 32'h100, p, o, s, si);
        tick(1, 1, 1, 0, 0, 32'h300, p, o, s, si);
        chk("prio_pop", o, 1);
        chk("prio_push", p, 0);
        chk("prio_depth", bus.depth, 1);
        tick(0, 0, 0, 0, 0, 32'h0, p, o, s, si);
        chk("prio_stall", s, 1);
        chk("prio_pc", bus.pc, 32'h101);

        // Reset during RET_WAIT
        do_reset();
        tick(1, 1, 0, 0, 0, 32'h200, p, o, s, si);
        tick(1, 0, 1, 0, 0, 32'h0, p, o, s, si);
        chk("rw_stall_pre", bus.stall, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_pc", bus.pc, 32'h0);
        chk("rw_stall", bus.stall, 0);
        chk("rw_depth", bus.depth, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1, 0, 0, 0, 0, 32'h0, p, o, s, si);
        chk("rw_after_pc", bus.pc, 32'h1);

        // Random run against the reference model
        do_reset();
        m_pc = 0; m_wait = 0; m_ovf = 0; m_unf = 0;
        q.delete();
        for (int i = 0; i < 500; i++) begin
            logic v, c, r, j, b, ep, eo, es;
            logic [31:0] t, esin;
            v = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            ep = 0; eo = 0; es = m_wait;
            if (!m_wait && v) begin
                if (r) eo = (q.size() > 0);
                else if (c) ep = (q.size() < 32);
            end
            esin = m_pc + 32'd1;
            tick(v, c, r, j, b, t, p, o, s, si);
            chk("rnd_push", p, ep);
            chk("rnd_pop", o, eo);
            chk("rnd_stall", s, es);
            chk("rnd_sin", si, esin);
            if (m_wait) begin
                m_pc = m_ret;
                m_wait = 0;
            end else if (v) begin
                if (r) begin
                    if (q.size() > 0) begin
                        m_ret = q.pop_back();
                        m_wait = 1;
                    end else begin
                        m_unf = 1;
                        m_pc = m_pc + 32'd1;
                    end
                end else if (c) begin
                    if (q.size() < 32) q.push_back(m_pc + 32'd1);
                    else m_ovf = 1;
                    m_pc = t;
                end else if (j || b) begin
                    m_pc = t;
                end else begin
                    m_pc = m_pc + 32'd1;
                end
            end
            chk("rnd_pc", bus.pc, m_pc);
            chk("rnd_depth", bus.depth, q.size());
            chk("rnd_ovf", bus.ovf_err, m_ovf);
            chk("rnd_unf", bus.unf_err, m_unf);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
